wb_regfile: RTL and testbench

- Write-back end of the MEM-stage writeback interface: consumes waddr/wdata/we from the MEM stage and commits them to the architectural register file.
- Contains the MEM/WB pipeline register with stall/flush, a 32x32 general-purpose register array with r0 hardwired to zero, and two decode-stage read ports.
- Read ports bypass the in-flight write-back so decode sees the value being committed this cycle.

---
 rtl/wb_regfile_pkg.sv | 26 ++
 rtl/wb_regfile_gpr_array.sv | 39 +++
 rtl/wb_regfile.sv | 73 +++++++
 tb/tb_wb_regfile.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared constants and types for the write-back register file
package wb_regfile_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int RegNum     = 32;

    localparam logic RstEnable    = 1'b1;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic ReadEnable   = 1'b1;
    localparam logic ReadDisable  = 1'b0;

    localparam logic [RegBus-1:0]     ZeroWord   = '0;
    localparam logic [RegAddrBus-1:0] NopRegAddr = '0;

    typedef logic [RegBus-1:0]     reg_bus_t;
    typedef logic [RegAddrBus-1:0] reg_addr_bus_t;

    typedef struct packed {
        logic          we;
        reg_addr_bus_t waddr;
        reg_bus_t      wdata;
    } wb_req_t;

endpackage

// File: rtl/wb_regfile_gpr_array.sv
// rtl/wb_regfile_gpr_array.sv - general-purpose register storage with one write and two raw read ports
module wb_regfile_gpr_array
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_wr_en;

    // r0 is never written, so its storage stays at the reset value of zero
    assign w_wr_en = (we == WriteEnable) && (waddr != '0);

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[waddr] <= wdata;
        end
    end

    assign rdata1 = r_regs[raddr1];
    assign rdata2 = r_regs[raddr2];

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - MEM/WB pipeline register plus register file with write-back bypass on both read ports
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_we,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [ADDR_W-1:0] wb_waddr_o,
    output logic [DATA_W-1:0] wb_wdata_o,
    output logic              wb_we_o
);

    logic [ADDR_W-1:0] r_wb_waddr;
    logic [DATA_W-1:0] r_wb_wdata;
    logic              r_wb_we;
    logic [DATA_W-1:0] w_raw1;
    logic [DATA_W-1:0] w_raw2;

    // Flush outranks stall so a squashed instruction never lingers in WB
    always_ff @(posedge clk) begin
        if (rst == RstEnable || flush) begin
            r_wb_waddr <= '0;
            r_wb_wdata <= '0;
            r_wb_we    <= WriteDisable;
        end else if (!stall) begin
            r_wb_waddr <= mem_waddr;
            r_wb_wdata <= mem_wdata;
            r_wb_we    <= mem_we;
        end
    end

    wb_regfile_gpr_array #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_gpr_array (
        .clk    (clk),
        .rst    (rst),
        .we     (r_wb_we),
        .waddr  (r_wb_waddr),
        .wdata  (r_wb_wdata),
        .raddr1 (raddr1),
        .raddr2 (raddr2),
        .rdata1 (w_raw1),
        .rdata2 (w_raw2)
    );

    // Bypass lets decode see the value committing this cycle before it lands in the array
    assign rdata1 = (rst == RstEnable || re1 == ReadDisable || raddr1 == '0) ? '0 :
                    (r_wb_we == WriteEnable && raddr1 == r_wb_waddr) ? r_wb_wdata : w_raw1;

    assign rdata2 = (rst == RstEnable || re2 == ReadDisable || raddr2 == '0) ? '0 :
                    (r_wb_we == WriteEnable && raddr2 == r_wb_waddr) ? r_wb_wdata : w_raw2;

    assign wb_waddr_o = r_wb_waddr;
    assign wb_wdata_o = r_wb_wdata;
    assign wb_we_o    = r_wb_we;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed vector table plus randomized model comparison for wb_regfile
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [4:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o;
    logic        wb_we_o;

    int n_vec;
    int n_bad;

    wb_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .re1        (re1),
        .raddr1     (raddr1),
        .rdata1     (rdata1),
        .re2        (re2),
        .raddr2     (raddr2),
        .rdata2     (rdata2),
        .wb_waddr_o (wb_waddr_o),
        .wb_wdata_o (wb_wdata_o),
        .wb_we_o    (wb_we_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        re1;
        logic [4:0]  ra1;
        logic        re2;
        logic [4:0]  ra2;
        logic        chk_wb;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
    } vec_t;

    vec_t vecs [19];

    // Reference state: committed architectural registers and the pending write-back slot
    logic [31:0] m_regs [32];
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic r, input logic en, input logic [4:0] a);
        if (r || !en || a == 5'd0) return 32'd0;
        if (m_we && a == m_waddr) return m_wdata;
        return m_regs[a];
    endfunction

    task automatic drive(input logic r, input logic s, input logic f, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
        rst       = r;
        stall     = s;
        flush     = f;
        mem_we    = we;
        mem_waddr = wa;
        mem_wdata = wd;
        re1       = e1;
        raddr1    = a1;
        re2       = e2;
        raddr2    = a2;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;

        //            rst stall flush we  waddr  wdata         re1 ra1   re2 ra2   chk  ewe ewaddr ewdata        erd1          erd2
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0000AAAA, 1'b1, 5'd3, 1'b1, 5'd3, 1'b0, 1'b0, 5'd0, 32'h0,        32'h0,        32'h0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0000AAAA, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 32'h0,        32'h0,        32'h0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 32'h0,        32'h0,        32'h0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        32'h0,        32'h0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        32'hDEADBEEF, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 32'h0,        32'h0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h12345678, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        32'h0,        32'h0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 5'd8, 32'h11111111, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 5'd7, 32'h12345678, 32'h12345678, 32'h12345678};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 32'h22222222, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 5'd7, 32'h12345678, 32'h12345678, 32'h12345678};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 32'h33333333, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 5'd7, 32'h12345678, 32'h12345678, 32'h12345678};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h44444444, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 5'd7, 32'h12345678, 32'h12345678, 32'h12345678};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 32'h0,        32'h12345678, 32'h12345678};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h1,        1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 32'h0,        32'h0,        32'h0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h2,        1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 5'd9, 32'h1,        32'h1,        32'h1};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 5'd9, 32'h2,        32'h0,        32'h2};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 32'h0,        32'h0,        32'h2};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 32'h00000055, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 32'h0,        32'h0,        32'h0};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 32'h0,        32'h0,        32'h0};

        #1;
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].we, vecs[i].waddr, vecs[i].wdata,
                  vecs[i].re1, vecs[i].ra1, vecs[i].re2, vecs[i].ra2);
            #2;
            check("dir_rdata1", i, rdata1, vecs[i].e_rd1);
            check("dir_rdata2", i, rdata2, vecs[i].e_rd2);
            if (vecs[i].chk_wb) begin
                check("dir_wb_we", i, {31'd0, wb_we_o}, {31'd0, vecs[i].e_we});
                check("dir_wb_waddr", i, {27'd0, wb_waddr_o}, {27'd0, vecs[i].e_waddr});
                check("dir_wb_wdata", i, wb_wdata_o, vecs[i].e_wdata);
            end
            @(posedge clk);
            #1;
        end

        // Directed sequence leaves the array and WB slot cleared
        for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
        m_we    = 1'b0;
        m_waddr = 5'd0;
        m_wdata = 32'd0;

        for (int c = 0; c < 600; c++) begin
            logic        r_rst, r_stall, r_flush, r_we, r_e1, r_e2;
            logic [4:0]  r_wa, r_a1, r_a2;
            logic [31:0] r_wd;
            r_rst   = ($urandom_range(40) == 0);
            r_stall = ($urandom_range(3) == 0);
            r_flush = ($urandom_range(7) == 0);
            r_we    = ($urandom_range(1) == 1);
            r_wa    = 5'($urandom_range(31));
            r_wd    = $urandom;
            r_e1    = ($urandom_range(3) != 0);
            r_e2    = ($urandom_range(3) != 0);
            r_a1    = ($urandom_range(2) == 0) ? m_waddr : 5'($urandom_range(31));
            r_a2    = ($urandom_range(2) == 0) ? r_a1 : 5'($urandom_range(31));
            drive(r_rst, r_stall, r_flush, r_we, r_wa, r_wd, r_e1, r_a1, r_e2, r_a2);
            #2;
            check("rnd_rdata1", c, rdata1, model_read(r_rst, r_e1, r_a1));
            check("rnd_rdata2", c, rdata2, model_read(r_rst, r_e2, r_a2));
            check("rnd_wb_we", c, {31'd0, wb_we_o}, {31'd0, m_we});
            check("rnd_wb_waddr", c, {27'd0, wb_waddr_o}, {27'd0, m_waddr});
            check("rnd_wb_wdata", c, wb_wdata_o, m_wdata);
            @(posedge clk);
            if (r_rst) begin
                for (int r = 0; r < 32; r++) m_regs[r] = 32'd0;
                m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
            end else begin
                if (m_we && m_waddr != 5'd0) m_regs[m_waddr] = m_wdata;
                if (r_flush) begin
                    m_we = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
                end else if (!r_stall) begin
                    m_we = r_we; m_waddr = r_wa; m_wdata = r_wd;
                end
            end
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
